// File: rtl/voice_allocator_pkg.sv
// rtl/voice_allocator_pkg.sv - shared FSM state type, default widths and the saturating age increment.
package voice_allocator_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } state_e;

  localparam int DEF_NOTE_W = 7;
  localparam int DEF_AGE_W  = 8;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/voice_slot.sv
// rtl/voice_slot.sv - one voice: note, gate and a saturating age that only advances while gated.
module voice_slot
  import voice_allocator_pkg::*;
#(
  parameter int NOTE_W = DEF_NOTE_W,
  parameter int AGE_W  = DEF_AGE_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [NOTE_W-1:0] note_i,
  input  logic              release_i,
  input  logic              retrigger_i,
  input  logic              age_inc_i,
  output logic [NOTE_W-1:0] note_o,
  output logic              gate_o,
  output logic [AGE_W-1:0]  age_o
);

  localparam logic [31:0] AGE_MAX = 32'((64'd1 << AGE_W) - 64'd1);

  logic [NOTE_W-1:0] note_q;
  logic              gate_q;
  logic [AGE_W-1:0]  age_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      note_q <= '0;
      gate_q <= 1'b0;
      age_q  <= '0;
    end else if (load_i) begin
      note_q <= note_i;
      gate_q <= 1'b1;
      age_q  <= '0;
    end else if (retrigger_i) begin
      age_q <= '0;
    end else if (release_i) begin
      gate_q <= 1'b0;
    end else if (age_inc_i && gate_q) begin
      age_q <= AGE_W'(sat_inc(32'(age_q), AGE_MAX));
    end
  end

  assign note_o = note_q;
  assign gate_o = gate_q;
  assign age_o  = age_q;

endmodule

// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - serial-scan polyphonic voice allocator; VOICE_ALLOCATOR_STEAL_EN enables stealing the oldest voice when full.
module voice_allocator
  import voice_allocator_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int NOTE_W     = DEF_NOTE_W,
  parameter int AGE_W      = DEF_AGE_W
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         ev_valid,
  output logic                         ev_ready,
  input  logic                         ev_on,
  input  logic [NOTE_W-1:0]            ev_note,
  output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
  output logic [NUM_VOICES-1:0]        voice_gate,
  output logic                         steal,
  output logic                         drop
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
`ifdef VOICE_ALLOCATOR_STEAL_EN
  localparam logic STEAL_EN = 1'b1;
`else
  localparam logic STEAL_EN = 1'b0;
`endif

  state_e            state_q;
  logic [IDX_W-1:0]  idx_q;
  logic              on_q;
  logic [NOTE_W-1:0] note_q;
  logic              match_q, free_q, old_q;
  logic [IDX_W-1:0]  match_idx_q, free_idx_q, old_idx_q;
  logic [AGE_W-1:0]  old_age_q;
  logic              ready_q, steal_q, drop_q;

  logic [NOTE_W-1:0]     s_note [NUM_VOICES];
  logic [AGE_W-1:0]      s_age  [NUM_VOICES];
  logic [NUM_VOICES-1:0] s_gate;

  logic [NOTE_W-1:0] cur_note;
  logic              cur_gate;
  logic [AGE_W-1:0]  cur_age;

  assign cur_note = s_note[idx_q];
  assign cur_gate = s_gate[idx_q];
  assign cur_age  = s_age[idx_q];

  logic [IDX_W-1:0]      tgt_idx;
  logic [NUM_VOICES-1:0] tgt_oh, load, retrig, rel, age_inc;
  logic                  do_steal, do_drop;

  // Match wins over free, free over oldest; for note-off the target is the match.
  always_comb begin
    tgt_idx = match_q ? match_idx_q : (free_q ? free_idx_q : old_idx_q);
    tgt_oh  = '0;
    tgt_oh[tgt_idx] = 1'b1;
    load     = '0;
    retrig   = '0;
    rel      = '0;
    age_inc  = '0;
    do_steal = 1'b0;
    do_drop  = 1'b0;
    if (state_q == COMMIT) begin
      if (!on_q) begin
        if (match_q) rel = tgt_oh;
      end else if (match_q) begin
        retrig  = tgt_oh;
        age_inc = ~tgt_oh;
      end else if (free_q) begin
        load    = tgt_oh;
        age_inc = ~tgt_oh;
      end else if (STEAL_EN) begin
        load     = tgt_oh;
        age_inc  = ~tgt_oh;
        do_steal = 1'b1;
      end else begin
        do_drop = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      on_q        <= 1'b0;
      note_q      <= '0;
      match_q     <= 1'b0;
      free_q      <= 1'b0;
      old_q       <= 1'b0;
      match_idx_q <= '0;
      free_idx_q  <= '0;
      old_idx_q   <= '0;
      old_age_q   <= '0;
      ready_q     <= 1'b0;
      steal_q     <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      steal_q <= 1'b0;
      drop_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (ev_valid && ready_q) begin
            on_q      <= ev_on;
            note_q    <= ev_note;
            idx_q     <= '0;
            match_q   <= 1'b0;
            free_q    <= 1'b0;
            old_q     <= 1'b0;
            old_age_q <= '0;
            ready_q   <= 1'b0;
            state_q   <= SCAN;
          end
        end
        SCAN: begin
          if (cur_gate && (cur_note == note_q) && !match_q) begin
            match_q     <= 1'b1;
            match_idx_q <= idx_q;
          end
          if (!cur_gate && !free_q) begin
            free_q     <= 1'b1;
            free_idx_q <= idx_q;
          end
          // Strict compare keeps the lowest index on equal ages.
          if (cur_gate && (!old_q || (cur_age > old_age_q))) begin
            old_q     <= 1'b1;
            old_idx_q <= idx_q;
            old_age_q <= cur_age;
          end
          if (idx_q == LAST_IDX) state_q <= COMMIT;
          else                   idx_q   <= idx_q + 1'b1;
        end
        COMMIT: begin
          steal_q <= do_steal;
          drop_q  <= do_drop;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_slot
    voice_slot #(
      .NOTE_W(NOTE_W),
      .AGE_W (AGE_W)
    ) u_slot (
      .clk_i      (clock),
      .rst_i      (reset),
      .load_i     (load[g]),
      .note_i     (note_q),
      .release_i  (rel[g]),
      .retrigger_i(retrig[g]),
      .age_inc_i  (age_inc[g]),
      .note_o     (s_note[g]),
      .gate_o     (s_gate[g]),
      .age_o      (s_age[g])
    );
    assign voice_note[g*NOTE_W +: NOTE_W] = s_note[g];
  end

  assign voice_gate = s_gate;
  assign ev_ready   = ready_q;
  assign steal      = steal_q;
  assign drop       = drop_q;

endmodule

// File: tb/tb_voice_allocator.sv
// tb/tb_voice_allocator.sv - scoreboard bench for voice_allocator against a rule-level voice model; honours VOICE_ALLOCATOR_STEAL_EN.
module tb_voice_allocator;

  localparam int N  = 4;
  localparam int NW = 7;
  localparam int AW = 8;
  localparam int AGE_MAX = (1 << AW) - 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          ev_valid = 1'b0;
  logic          ev_ready;
  logic          ev_on = 1'b0;
  logic [NW-1:0] ev_note = '0;
  logic [N*NW-1:0] voice_note;
  logic [N-1:0]    voice_gate;
  logic          steal, drop;

  voice_allocator #(.NUM_VOICES(N), .NOTE_W(NW), .AGE_W(AW)) dut (
    .clock     (clock),
    .reset     (reset),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ev_on     (ev_on),
    .ev_note   (ev_note),
    .voice_note(voice_note),
    .voice_gate(voice_gate),
    .steal     (steal),
    .drop      (drop)
  );

  always #5 clock = ~clock;

  wire [N*AW-1:0] dut_age;
  for (genvar g = 0; g < N; g++) begin : g_age
    assign dut_age[g*AW +: AW] = dut.g_slot[g].u_slot.age_o;
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [N*NW-1:0] note;
    logic [N-1:0]    gate;
    logic [N*AW-1:0] age;
    logic            stl;
    logic            drp;
    int              acc;
  } exp_t;

  exp_t sb[$];

  int m_note[N];
  bit m_gate[N];
  int m_age[N];

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_note[i] = 0;
      m_gate[i] = 1'b0;
      m_age[i]  = 0;
    end
  endtask

  task automatic model_event(input bit on, input int n, output bit stl, output bit drp);
    int match = -1;
    int free  = -1;
    int old   = -1;
    int tgt;
    stl = 1'b0;
    drp = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (m_gate[i] && m_note[i] == n && match < 0) match = i;
      if (!m_gate[i] && free < 0) free = i;
      if (m_gate[i] && (old < 0 || m_age[i] > m_age[old])) old = i;
    end
    if (!on) begin
      if (match >= 0) m_gate[match] = 1'b0;
      return;
    end
    if (match >= 0) tgt = match;
    else if (free >= 0) tgt = free;
    else begin
`ifdef VOICE_ALLOCATOR_STEAL_EN
      tgt = old;
      stl = 1'b1;
`else
      drp = 1'b1;
      return;
`endif
    end
    for (int i = 0; i < N; i++)
      if (i != tgt && m_gate[i]) m_age[i] = (m_age[i] >= AGE_MAX) ? AGE_MAX : m_age[i] + 1;
    m_note[tgt] = n;
    m_gate[tgt] = 1'b1;
    m_age[tgt]  = 0;
  endtask

  task automatic send(input bit on, input int n, input bit noise);
    exp_t e;
    bit s, d;
    int t = 0;
    @(negedge clock);
    while (!ev_ready && t < 60) begin
      @(negedge clock);
      t++;
    end
    chk("ready_timeout", ev_ready, 1);
    if (!ev_ready) return;
    ev_valid = 1'b1;
    ev_on    = on;
    ev_note  = NW'(n);
    model_event(on, n, s, d);
    for (int i = 0; i < N; i++) begin
      e.note[i*NW +: NW] = NW'(m_note[i]);
      e.gate[i]          = m_gate[i];
      e.age[i*AW +: AW]  = AW'(m_age[i]);
    end
    e.stl = s;
    e.drp = d;
    @(posedge clock);
    #1;
    e.acc = cyc;
    sb.push_back(e);
    if (noise) begin
      // Garbage while busy must be ignored; cleared before ev_ready can return.
      for (int k = 0; k < N; k++) begin
        ev_valid = 1'($urandom_range(0, 1));
        ev_on    = 1'($urandom_range(0, 1));
        ev_note  = NW'($urandom);
        @(negedge clock);
      end
      ev_valid = 1'b0;
    end
  endtask

  task automatic apply_reset();
    ev_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_gate", voice_gate, 0);
    chk("rst_note", voice_note, 0);
    chk("rst_ready", ev_ready, 0);
    chk("rst_steal_drop", {steal, drop}, 0);
    sb.delete();
    model_clear();
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    apply_reset();
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((sb.size() != 0 || !ev_ready) && t < 100) begin
      @(negedge clock);
      t++;
    end
    chk("idle_timeout", (t < 100), 1);
  endtask

  initial begin : monitor
    bit prev = 1'b0;
    bit after = 1'b0;
    exp_t e;
    forever begin
      @(negedge clock);
      if (after) begin
        chk("steal_one_cycle", steal, 0);
        chk("drop_one_cycle", drop, 0);
        after = 1'b0;
      end
      if (ev_ready && !prev && sb.size() > 0) begin
        e = sb.pop_front();
        chk("commit_latency", cyc - e.acc, N + 1);
        chk("voice_note", voice_note, e.note);
        chk("voice_gate", voice_gate, e.gate);
        chk("voice_age", dut_age, e.age);
        chk("steal", steal, e.stl);
        chk("drop", drop, e.drp);
        after = 1'b1;
      end
      prev = ev_ready;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    model_clear();
    do_reset();
    wait_idle();

    send(1, 60, 1); send(1, 62, 1); send(1, 64, 1); send(1, 65, 1);
    send(1, 67, 1);
    wait_idle();

    do_reset();
    send(1, 60, 1); send(1, 62, 1); send(0, 62, 1); send(1, 70, 1);
    wait_idle();

    do_reset();
    send(1, 60, 1); send(1, 60, 1); send(0, 99, 1);
    wait_idle();

    do_reset();
    wait_idle();
    send(1, 60, 0);
    ev_valid = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    apply_reset();
    repeat (N + 4) @(negedge clock);
    chk("abort_gate", voice_gate, 0);
    chk("abort_note", voice_note, 0);
    chk("abort_ready", ev_ready, 1);

    // Drive voice0 age into saturation, then fill and overflow.
    do_reset();
    send(1, 10, 1);
    repeat (AGE_MAX + 3) send(1, 20, 1);
    send(1, 30, 1); send(1, 40, 1); send(1, 50, 1); send(1, 55, 1);
    wait_idle();

    do_reset();
    repeat (400) begin
      int n;
      n = 60 + $urandom_range(0, 7);
      if ($urandom_range(0, 19) == 0) n = ($urandom_range(0, 1) != 0) ? 127 : 0;
      send($urandom_range(0, 99) < 65, n, 1);
    end
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
